axi_to_bus: RTL and testbench

//  AXI3 32-bit slave (6-bit IDs, 4-bit len) that masters our MemoryBus, letting PS/DMA AXI masters reach bus targets.

---
 rtl/axi_to_bus.sv | 187 ++++++++++++++++++
 tb/tb_axi_to_bus.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_to_bus.sv
// AXI3 32-bit slave that masters MemoryBus, one single-beat bus transaction at a time.
// Optional read watchdog: define AXI_TO_BUS_TIMEOUT_EN.
module axi_to_bus #(
  parameter logic [1:0] ID_PREFIX      = 2'b10,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        msValid,
  output logic        msWrite,
  output logic [7:0]  msID,
  output logic [29:0] msAddress,
  output logic [23:0] msData,
  input  logic        msTaken,
  input  logic        smValid,
  input  logic [7:0]  smID,
  input  logic [23:0] smData,
  output logic        smTaken,
  input  logic [31:0] araddr,
  input  logic [5:0]  arid,
  input  logic [3:0]  arlen,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] awaddr,
  input  logic [5:0]  awid,
  input  logic [3:0]  awlen,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  input  logic [5:0]  wid,
  output logic        wready,
  output logic [5:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [5:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_DATA, WR_ISSUE, WR_RESP} state_t;

  state_t      state, state_nxt;
  logic        rdy_q, prio_wr;
  logic [5:0]  id_q;
  logic [3:0]  len_q, count_q;
  logic [1:0]  burst_q;
  logic [29:0] addr_q;
  logic        err_q, wlast_q;
  logic [23:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        ar_hs, aw_hs, conflict, sm_match, timeout;
  logic        beat_done, beat_end, beat_err, last_flag;

  function automatic logic [29:0] addr_next(input logic [29:0] a, input logic [1:0] b);
    return (b == 2'b00) ? a : a + 30'd1;
  endfunction

  logic unused;
  assign unused = ^{araddr[1:0], awaddr[1:0], wdata[31:24], wid};

  // Ready is registered so it stays low during and right after reset.
  assign conflict = arvalid && awvalid;
  assign arready  = rdy_q && !(conflict && prio_wr);
  assign awready  = rdy_q && !(conflict && !prio_wr);
  assign ar_hs    = arvalid && arready;
  assign aw_hs    = awvalid && awready;

  assign msValid   = (state == RD_ISSUE) || (state == WR_ISSUE);
  assign msWrite   = (state == WR_ISSUE);
  assign msID      = {ID_PREFIX, id_q};
  assign msAddress = addr_q;
  assign msData    = wdata_q;
  assign sm_match  = (state == RD_WAIT) && smValid && (smID == {ID_PREFIX, id_q});
  assign smTaken   = sm_match;

  assign wready = (state == WR_DATA);
  assign rvalid = (state == RD_RESP);
  assign rlast  = rvalid && (count_q == len_q);
  assign rid    = id_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign bvalid = (state == WR_RESP);
  assign bid    = id_q;
  assign bresp  = (bvalid && err_q) ? 2'b10 : 2'b00;

`ifdef AXI_TO_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;
  assign timeout = (state == RD_WAIT) && !sm_match && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                tmr_q <= '0;
    else if (state == RD_ISSUE && msTaken)    tmr_q <= '0;
    else if (state == RD_WAIT)                tmr_q <= tmr_q + TW'(1);
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    beat_done = 1'b0;
    last_flag = (state == WR_DATA) ? wlast : wlast_q;
    case (state)
      IDLE:     if (ar_hs) state_nxt = RD_ISSUE;
                else if (aw_hs) state_nxt = WR_DATA;
      RD_ISSUE: if (msTaken) state_nxt = RD_WAIT;
      RD_WAIT:  if (sm_match || timeout) state_nxt = RD_RESP;
      RD_RESP:  if (rready) state_nxt = (count_q == len_q) ? IDLE : RD_ISSUE;
      WR_DATA:  if (wvalid) begin
                  if (wstrb != 4'hF) beat_done = 1'b1;
                  else state_nxt = WR_ISSUE;
                end
      WR_ISSUE: if (msTaken) beat_done = 1'b1;
      WR_RESP:  if (bready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // Burst ends at len or wlast, whichever comes first; disagreement is an error.
    beat_end = (count_q == len_q) || last_flag;
    beat_err = last_flag != (count_q == len_q);
    if (beat_done) state_nxt = beat_end ? WR_RESP : WR_DATA;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      rdy_q   <= 1'b0;
      prio_wr <= 1'b0;
      id_q    <= '0;
      len_q   <= '0;
      count_q <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      wlast_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
      if (state == IDLE && rdy_q && conflict) prio_wr <= !prio_wr;
      if (ar_hs) begin
        id_q <= arid; len_q <= arlen; burst_q <= arburst; addr_q <= araddr[31:2];
        count_q <= '0; err_q <= 1'b0;
      end else if (aw_hs) begin
        id_q <= awid; len_q <= awlen; burst_q <= awburst; addr_q <= awaddr[31:2];
        count_q <= '0; err_q <= 1'b0;
      end
      if (sm_match) begin
        rdata_q <= {8'h00, smData};
        rresp_q <= 2'b00;
      end else if (timeout) begin
        rdata_q <= '0;
        rresp_q <= 2'b10;
      end
      if (state == RD_RESP && rready && count_q != len_q) begin
        count_q <= count_q + 4'd1;
        addr_q  <= addr_next(addr_q, burst_q);
      end
      if (state == WR_DATA && wvalid) begin
        wdata_q <= wdata[23:0];
        wlast_q <= wlast;
        if (wstrb != 4'hF) err_q <= 1'b1;
      end
      if (beat_done) begin
        if (beat_err) err_q <= 1'b1;
        if (!beat_end) begin
          count_q <= count_q + 4'd1;
          addr_q  <= addr_next(addr_q, burst_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_to_bus.sv
// Directed self-checking bench for axi_to_bus; timeout case runs when AXI_TO_BUS_TIMEOUT_EN is defined.
module tb_axi_to_bus;
  logic        clk = 1'b0;
  logic        rstn;
  logic        msValid, msWrite, msTaken, smValid, smTaken;
  logic [7:0]  msID, smID;
  logic [29:0] msAddress;
  logic [23:0] msData, smData;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [5:0]  arid, awid, wid, bid, rid;
  logic [3:0]  arlen, awlen, wstrb;
  logic [1:0]  arburst, awburst, bresp, rresp;
  logic        arvalid, arready, awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, rlast, rvalid, rready;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_to_bus #(.ID_PREFIX(2'b10), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn),
    .msValid(msValid), .msWrite(msWrite), .msID(msID), .msAddress(msAddress), .msData(msData),
    .msTaken(msTaken), .smValid(smValid), .smID(smID), .smData(smData), .smTaken(smTaken),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wid(wid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len, input logic [1:0] b);
    int n = 0;
    araddr = a; arid = id; arlen = len; arburst = b; arvalid = 1'b1; #1;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    chk("ar_ready", arready, 1);
    @(negedge clk); arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len, input logic [1:0] b);
    int n = 0;
    awaddr = a; awid = id; awlen = len; awburst = b; awvalid = 1'b1; #1;
    while (!awready && n < 50) begin @(negedge clk); #1; n++; end
    chk("aw_ready", awready, 1);
    @(negedge clk); awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1; #1;
    while (!wready && n < 50) begin @(negedge clk); #1; n++; end
    chk("w_ready", wready, 1);
    @(negedge clk); wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic bus_read(input logic [29:0] a, input logic [7:0] mid, input logic [23:0] d);
    int n = 0;
    #1;
    while (!msValid && n < 50) begin @(negedge clk); #1; n++; end
    chk("rd_msvalid", msValid, 1);
    chk("rd_mswrite", msWrite, 0);
    chk("rd_msid", msID, mid);
    chk("rd_addr", msAddress, a);
    @(negedge clk); #1;
    chk("rd_hold", {msValid, 2'b00, msAddress}, {1'b1, 2'b00, a});
    msTaken = 1'b1;
    @(negedge clk); msTaken = 1'b0;
    smValid = 1'b1; smID = mid ^ 8'h01; smData = ~d; #1;
    chk("sm_ignore", smTaken, 0);
    @(negedge clk); smID = mid; smData = d; #1;
    chk("sm_taken", smTaken, 1);
    @(negedge clk); smValid = 1'b0;
  endtask

  task automatic r_check(input logic [5:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
    int n = 0;
    #1;
    while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
    chk("r_valid", rvalid, 1);
    chk("r_id", rid, id);
    chk("r_data", rdata, d);
    chk("r_resp", rresp, resp);
    chk("r_last", rlast, last);
    rready = 1'b1;
    @(negedge clk); rready = 1'b0;
  endtask

  task automatic bus_write(input logic [29:0] a, input logic [23:0] d, input logic [7:0] mid);
    int n = 0;
    #1;
    while (!msValid && n < 50) begin @(negedge clk); #1; n++; end
    chk("wr_msvalid", msValid, 1);
    chk("wr_mswrite", msWrite, 1);
    chk("wr_addr", msAddress, a);
    chk("wr_data", msData, d);
    chk("wr_msid", msID, mid);
    msTaken = 1'b1;
    @(negedge clk); msTaken = 1'b0;
  endtask

  task automatic b_check(input logic [5:0] id, input logic [1:0] resp);
    int n = 0;
    #1;
    while (!bvalid && n < 50) begin @(negedge clk); #1; n++; end
    chk("b_valid", bvalid, 1);
    chk("b_id", bid, id);
    chk("b_resp", bresp, resp);
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; msTaken = 0; smValid = 0; smID = 0; smData = 0;
    araddr = 0; arid = 0; arlen = 0; arburst = 0; arvalid = 0;
    awaddr = 0; awid = 0; awlen = 0; awburst = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; wid = 0; bready = 0; rready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valids", {msValid, rvalid, bvalid, wready, smTaken}, 0);
    chk("rst_ready", {arready, awready}, 0);
    chk("rst_fields", {rdata, msAddress, msData, rid, bid, rresp, bresp}, 0);
    @(negedge clk); rstn = 1'b1;

    // Single read, 24-bit data zero-extended
    ar_send(32'h100, 6'd5, 4'd0, 2'b01);
    bus_read(30'h40, 8'h85, 24'hABCDEF);
    #1; chk("r_wait_rready", 0, 0 | {31'b0, rvalid} ^ 32'h1);
    @(negedge clk);
    r_check(6'd5, 32'h00ABCDEF, 2'b00, 1'b1);
    #1; chk("r_done", rvalid, 0);

    // 4-beat INCR write
    aw_send(32'h40, 6'd9, 4'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      w_beat({8'hA5, 8'(i + 1), 16'hBEEF}, 4'hF, i == 3);
      bus_write(30'h10 + 30'(i), {8'(i + 1), 16'hBEEF}, 8'h89);
    end
    b_check(6'd9, 2'b00);

    // Simultaneous AR/AW twice: read, write, then the second read
    araddr = 32'h200; arid = 6'd1; arlen = 0; arburst = 2'b01; arvalid = 1'b1;
    awaddr = 32'h80;  awid = 6'd2; awlen = 0; awburst = 2'b01; awvalid = 1'b1;
    #1; chk("arb1_ar", arready, 1); chk("arb1_aw", awready, 0);
    @(negedge clk); arvalid = 1'b0;
    bus_read(30'h80, 8'h81, 24'h111111);
    r_check(6'd1, 32'h00111111, 2'b00, 1'b1);
    araddr = 32'h300; arid = 6'd3; arvalid = 1'b1;
    #1; chk("arb2_aw", awready, 1); chk("arb2_ar", arready, 0);
    @(negedge clk); awvalid = 1'b0;
    w_beat(32'hFF222222, 4'hF, 1'b1);
    bus_write(30'h20, 24'h222222, 8'h82);
    b_check(6'd2, 2'b00);
    #1; chk("arb3_ar", arready, 1);
    @(negedge clk); arvalid = 1'b0;
    bus_read(30'hC0, 8'h83, 24'h333333);
    r_check(6'd3, 32'h00333333, 2'b00, 1'b1);

    // Partial strobe beat dropped, SLVERR
    aw_send(32'h10, 6'd4, 4'd1, 2'b01);
    w_beat(32'h00DEAD00, 4'h3, 1'b0);
    #1; chk("drop_noms", msValid, 0); chk("drop_wready", wready, 1);
    w_beat(32'h00CAFE01, 4'hF, 1'b1);
    bus_write(30'h5, 24'hCAFE01, 8'h84);
    b_check(6'd4, 2'b10);

    // INCR read across the 30-bit address wrap
    ar_send(32'hFFFF_FFFC, 6'h0A, 4'd1, 2'b01);
    bus_read(30'h3FFF_FFFF, 8'h8A, 24'h0000AA);
    r_check(6'h0A, 32'h000000AA, 2'b00, 1'b0);
    bus_read(30'h0, 8'h8A, 24'h0000BB);
    r_check(6'h0A, 32'h000000BB, 2'b00, 1'b1);

    // FIXED write holds the address
    aw_send(32'h8, 6'h0B, 4'd1, 2'b00);
    w_beat(32'h00000011, 4'hF, 1'b0);
    bus_write(30'h2, 24'h000011, 8'h8B);
    w_beat(32'h00000022, 4'hF, 1'b1);
    bus_write(30'h2, 24'h000022, 8'h8B);
    b_check(6'h0B, 2'b00);

    // Early wlast ends a 3-beat burst after 2 beats with SLVERR
    aw_send(32'h60, 6'h0C, 4'd2, 2'b01);
    w_beat(32'h00000033, 4'hF, 1'b0);
    bus_write(30'h18, 24'h000033, 8'h8C);
    w_beat(32'h00000044, 4'hF, 1'b1);
    bus_write(30'h19, 24'h000044, 8'h8C);
    b_check(6'h0C, 2'b10);
    #1; chk("early_last_idle", {wready, arready}, 2'b01);

    // Reset while waiting for read data, then a fresh read
    ar_send(32'h400, 6'd7, 4'd3, 2'b01);
    #1; chk("rst5_issue", msValid, 1);
    msTaken = 1'b1;
    @(negedge clk); msTaken = 1'b0;
    repeat (5) @(negedge clk);
    #1; chk("rst5_stuck", {rvalid, msValid}, 0);
    rstn = 1'b0; #1;
    chk("rst5_outs", {msValid, rvalid, bvalid, wready, arready, awready, smTaken}, 0);
    chk("rst5_fields", {rdata, msAddress, rid}, 0);
    @(negedge clk); @(negedge clk); rstn = 1'b1;
    ar_send(32'h104, 6'd6, 4'd0, 2'b01);
    bus_read(30'h41, 8'h86, 24'h123456);
    r_check(6'd6, 32'h00123456, 2'b00, 1'b1);

`ifdef AXI_TO_BUS_TIMEOUT_EN
    begin
      int n = 0;
      ar_send(32'h8, 6'd2, 4'd0, 2'b01);
      #1; chk("to_issue", msValid, 1);
      msTaken = 1'b1;
      @(negedge clk); msTaken = 1'b0;
      #1;
      while (!rvalid && n < 40) begin @(negedge clk); #1; n++; end
      chk("to_cycles", n, 16);
      smValid = 1'b1; smID = 8'h82; smData = 24'h777777; #1;
      chk("to_late_ignored", smTaken, 0);
      smValid = 1'b0;
      r_check(6'd2, 32'h0, 2'b10, 1'b1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
